// File: rtl/s838_fi_shell.sv
// s838_fi_shell
// Sequential shell around the combinational s838 core. Holds the 32-bit Y
// state register, drives it to the core and captures the core's next state
// each RUN cycle. A bounded fault-injection session can flip chosen Y bits on
// one chosen run cycle. Over the session, the core's Z/W outputs are
// compacted into a MISR signature, so a golden run and a faulty run can be
// compared.
//
// Ports
//   CK, RST         clock (rising edge), synchronous active-high reset
//   start           one-cycle session start pulse (honoured only in IDLE)
//   cfg_cycles      session length in cycles (0 = immediate DONE)
//   cfg_inj_cycle   0-based run cycle at which the mask is applied
//   cfg_inj_mask    bit k-1 flips Y_k (0 = golden run)
//   X_in, clear_in  core inputs; wired to the core one level up
//   core_y          Y register to core (bit k-1 = Y_k)
//   core_next       core next-state outputs (bit k-1 = next Y_k)
//   core_z, core_w  core Z / W outputs
//   busy            high while in RUN
//   done            one-cycle pulse on entry to DONE
//   z_q, w_q        registered Z / W
//   signature       MISR value, held after DONE
//   final_y         Y snapshot at session end
//
// Optional build macro SCAN_CHAIN_EN adds scan_en/scan_in/scan_out. When
// scan_en=1, Y shifts toward Y_32 and all other state freezes.

module s838_fi_shell #(
  parameter int CNT_W = 16,
  parameter int SIG_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [CNT_W-1:0] cfg_inj_cycle,
  input  logic [31:0]      cfg_inj_mask,
  input  logic             X_in,
  input  logic             clear_in,
  output logic [31:0]      core_y,
  input  logic [31:0]      core_next,
  input  logic             core_z,
  input  logic             core_w,
  output logic             busy,
  output logic             done,
  output logic             z_q,
  output logic             w_q,
  output logic [SIG_W-1:0] signature,
  output logic [31:0]      final_y
`ifdef SCAN_CHAIN_EN
  ,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Galois taps below the implicit x^SIG_W term.
  localparam logic [SIG_W-1:0] TAPS = (SIG_W == 32) ? SIG_W'(64'h0040_0007)
                                                    : SIG_W'(64'h0000_1021);

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic z,
                                                 input logic w);
    logic [SIG_W-1:0] n;
    n = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) n = n ^ TAPS;
    n[1:0] = n[1:0] ^ {w, z};
    return n;
  endfunction

  state_t           state_q;
  logic [31:0]      y_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] inj_q;
  logic [31:0]      mask_q;
  logic [SIG_W-1:0] sig_q;

  logic [31:0]      y_d;
  logic [SIG_W-1:0] sig_d;
  logic             last_d;

  // X_in and clear_in feed the core directly at the level above; the shell
  // only carries them through its port list.
  logic unused_core_ins;
  assign unused_core_ins = X_in ^ clear_in;

  assign core_y    = y_q;
  assign signature = sig_q;
`ifdef SCAN_CHAIN_EN
  assign scan_out  = y_q[31];
`endif

  always_comb begin
    y_d    = core_next ^ ((cnt_q == inj_q) ? mask_q : 32'h0);
    sig_d  = misr_step(sig_q, core_z, core_w);
    // cyc_q >= 1 whenever RUN is active, so the subtraction never wraps there.
    last_d = (cnt_q == (cyc_q - CNT_W'(1)));
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      inj_q   <= '0;
      mask_q  <= '0;
      sig_q   <= '0;
      z_q     <= 1'b0;
      w_q     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      final_y <= '0;
    end else begin
`ifdef SCAN_CHAIN_EN
      if (scan_en) begin
        y_q <= {y_q[30:0], scan_in};
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              cyc_q  <= cfg_cycles;
              inj_q  <= cfg_inj_cycle;
              mask_q <= cfg_inj_mask;
              y_q    <= '0;
              cnt_q  <= '0;
              sig_q  <= '0;
              if (cfg_cycles == '0) begin
                state_q <= S_DONE;
                done    <= 1'b1;
                final_y <= '0;
              end else begin
                state_q <= S_RUN;
                busy    <= 1'b1;
              end
            end
          end
          S_RUN: begin
            y_q   <= y_d;
            z_q   <= core_z;
            w_q   <= core_w;
            sig_q <= sig_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_d) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              final_y <= y_d;
            end
          end
          S_DONE: begin
            done    <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/s838_fi_shell.md
Name: s838_fi_shell

Overview:
Sequential shell around the combinational s838 core. It owns the 32-bit Y state register, drives the core's Y_1..Y_32 inputs and captures the core's next-state outputs. It also runs a bounded fault-injection session: it flips chosen state bits on one chosen cycle and compacts the core's Z/W outputs into a signature for golden-vs-faulty comparison.

Parameters:
CNT_W, 16, width of session cycle counter and cycle-count configuration
SIG_W, 16, width of Z/W MISR signature (16 or 32 only)

Ports:
CK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; starts session, ignored unless IDLE
cfg_cycles  in  CNT_W  run length in cycles; 0 means immediate DONE
cfg_inj_cycle  in  CNT_W  run-cycle index (0-based) at which injection applies
cfg_inj_mask  in  32  bit k-1 flips Y_k; 0 = golden run
X_in  in  1  core X input, passed through combinationally
clear_in  in  1  core Clear input, passed through combinationally
core_y  out  32  state to core; bit k-1 drives Y_k
core_next  in  32  core next state; bit k-1 = core output for Y_k (n90,n85,n80,n75,n110,...,n215 order)
core_z  in  1  core Z
core_w  in  1  core W
busy  out  1  high in RUN
done  out  1  one-cycle pulse on entry to DONE
z_q  out  1  registered Z
w_q  out  1  registered W
signature  out  SIG_W  MISR value, held after DONE
final_y  out  32  Y register snapshot at session end

Behaviour:
- Reset (RST=1 at an edge): Y=0, FSM=IDLE, counter=0, signature=0, z_q=w_q=0, busy=done=0, final_y=0. Reset mid-RUN aborts the session with no done pulse.
- core_y = Y register at all times (no added combinational path).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Y holds.
  - On start: latch cfg_cycles, cfg_inj_cycle and cfg_inj_mask; clear Y, counter and signature.
  - Go to RUN, or to DONE if latched cfg_cycles=0.
- RUN, each cycle:
  - Y <= core_next, XOR latched mask when counter == latched inj_cycle.
  - z_q <= core_z; w_q <= core_w.
  - signature <= MISR step: shift left 1; XOR feedback of MSB into Galois taps (x^16+x^12+x^5+1 for 16; x^32+x^22+x^2+x+1 for 32); XOR {core_w,core_z} into bits [1:0].
  - counter++.
  - When counter == cycles-1 at the edge: go to DONE and final_y <= value written to Y that edge.
  - If inj_cycle >= cycles, no injection occurs.
- Latency: Y update is 1 cycle after core_next; session ends exactly cycles edges after the start edge.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - Y, signature and final_y hold until the next start.
- start asserted during RUN or DONE is ignored.
- Counter does not wrap within a session: max cycles = 2^CNT_W-1.
- Core semantics the bench relies on:
  - X=1 and Clear=0 → Y increments (Y_1 LSB), wrapping 0xFFFFFFFF→0.
  - X=0 or Clear=1 → next Y=0.

Optional Feature:
SCAN_CHAIN_EN: adds ports scan_en (in 1), scan_in (in 1), scan_out (out 1). When scan_en=1 (any FSM state, RST low):
- Y shifts toward Y_32: Y_1 <= scan_in; scan_out = Y_32 (combinational from register).
- FSM, counter and signature freeze.
- scan_en has priority over RUN updates.
Without the macro: ports absent, no scan mux in Y path.

Test Plan:
- RST, start with cycles=5, mask=0, X_in=1, clear_in=0 → final_y=0x00000005; done pulse 5 cycles after start edge; busy high 5 cycles.
- cycles=5, inj_cycle=2, mask=0x00000100, X_in=1 → final_y=0x00000105; signature differs from golden run with identical config and mask=0.
- Y preloaded near wrap (via scan or extended run), X_in=1 across wrap → Y goes 0xFFFFFFFF→0x00000000; W core output sampled as 1 in z/w path when Y_29..Y_32 all set.
- cycles=10, X_in=1 for 4 cycles then clear_in=1 → final_y=0; counter still completes 10 cycles, done pulses once.
- RST asserted at run cycle 3 of 8 → no done pulse, Y=0, FSM IDLE; new start runs normally.
- cycles=0 → done pulses the cycle after start; final_y=0, signature=0; start during RUN ignored (session length unchanged).
